hms_time_counter: RTL and testbench

//  Parametrised hours:minutes:seconds time-of-day counter. Successor to the
//  two-field sec/min counter: adds an on-chip tick prescaler, an hours field,
//  run/pause, up/down mode, synchronous time load and wrap pulses. Feeds the

---
 rtl/hms_time_counter_pkg.sv | 34 +++
 rtl/hms_time_counter_mod_counter.sv | 57 +++++
 rtl/hms_time_counter.sv | 107 ++++++++++
 tb/tb_hms_time_counter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/hms_time_counter_pkg.sv
// Shared defaults and elaboration helpers for the hours:minutes:seconds counter.
package hms_time_counter_pkg;

  // Default clock is 50 MHz, so one counted second every 50M cycles.
  localparam int DEF_TICK_DIV = 50_000_000;
  localparam int DEF_SEC_MOD  = 60;
  localparam int DEF_MIN_MOD  = 60;
  localparam int DEF_HR_MOD   = 24;
  localparam int DEF_W        = 8;

  // Field order inside the carry chain: seconds feed minutes feed hours.
  localparam int NUM_FIELDS = 3;
  localparam int FIELD_SEC  = 0;
  localparam int FIELD_MIN  = 1;
  localparam int FIELD_HR   = 2;

  // Prescaler width; a divide-by-one prescaler still needs a 1-bit register.
  function automatic int pre_width(input int div);
    return (div > 1) ? $clog2(div) : 1;
  endfunction

  // Modulus of the field at position idx in the carry chain.
  function automatic int field_mod(input int idx, input int sec_mod,
                                   input int min_mod, input int hr_mod);
    int result;
    case (idx)
      FIELD_SEC: result = sec_mod;
      FIELD_MIN: result = min_mod;
      default:   result = hr_mod;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/hms_time_counter_mod_counter.sv
// Single modulo-MOD up/down field with synchronous load and a combinational
// wrap output used as the enable of the next field in the chain.
module mod_counter
  import hms_time_counter_pkg::*;
#(
  parameter int MOD = DEF_SEC_MOD,
  parameter int W   = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         down,
  input  logic         load,
  input  logic [W-1:0] ld_val,
  output logic [W-1:0] cnt,
  output logic         wrap
);

  // The modulus may equal 2**W, so the range check is done one bit wider.
  localparam logic [W-1:0] TOP_VAL = W'(MOD - 1);
  localparam logic [W:0]   MOD_VAL = (W+1)'(MOD);

  logic [W-1:0] cnt_reg;
  logic [W-1:0] cnt_next;
  logic         at_terminal;
  logic         ld_ok;

  // Terminal count depends on direction: top value going up, zero going down.
  assign at_terminal = down ? (cnt_reg == '0) : (cnt_reg == TOP_VAL);
  assign wrap        = en & at_terminal;
  assign ld_ok       = ({1'b0, ld_val} < MOD_VAL);
  assign cnt         = cnt_reg;

  // Next value: load wins, otherwise step (with wraparound) when enabled.
  always_comb begin
    cnt_next = cnt_reg;
    if (load) begin
      cnt_next = ld_ok ? ld_val : '0;
    end else if (en) begin
      if (at_terminal) begin
        cnt_next = down ? TOP_VAL : '0;
      end else begin
        cnt_next = down ? (cnt_reg - W'(1)) : (cnt_reg + W'(1));
      end
    end
  end

  // Field register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_next;
    end
  end

endmodule

// File: rtl/hms_time_counter.sv
// Time-of-day counter: tick prescaler, three chained modulo fields
// (sec -> min -> hr), run/pause, up/down, synchronous load and event pulses.
module hms_time_counter
  import hms_time_counter_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV,
  parameter int SEC_MOD  = DEF_SEC_MOD,
  parameter int MIN_MOD  = DEF_MIN_MOD,
  parameter int HR_MOD   = DEF_HR_MOD,
  parameter int W        = DEF_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  input  logic         down,
  input  logic         load,
  input  logic [W-1:0] ld_sec,
  input  logic [W-1:0] ld_min,
  input  logic [W-1:0] ld_hr,
  output logic [W-1:0] sec,
  output logic [W-1:0] min,
  output logic [W-1:0] hr,
  output logic         sec_pulse,
  output logic         day_wrap,
  output logic         load_err
);

  localparam int             PW      = pre_width(TICK_DIV);
  localparam logic [PW-1:0]  PRE_MAX = PW'(TICK_DIV - 1);

  logic [PW-1:0]                  pre_reg;
  logic [PW-1:0]                  pre_next;
  logic                           tick;
  logic [NUM_FIELDS:0]            carry;
  logic [NUM_FIELDS-1:0][W-1:0]   ld_vec;
  logic [NUM_FIELDS-1:0][W-1:0]   field_cnt;
  logic [NUM_FIELDS-1:0]          ld_bad;
  logic                           sec_pulse_reg;
  logic                           day_wrap_reg;
  logic                           load_err_reg;

  // A load suppresses the tick so the freshly loaded time is not stepped.
  assign tick     = run & ~load & (pre_reg == PRE_MAX);
  assign carry[0] = tick;
  assign ld_vec   = {ld_hr, ld_min, ld_sec};
  assign {hr, min, sec} = field_cnt;

  // One field per chain position; each field's wrap enables the next.
  // down is shared, so it only matters on edges where a tick is consumed.
  for (genvar gi = 0; gi < NUM_FIELDS; gi++) begin : g_field
    localparam int          FMOD     = field_mod(gi, SEC_MOD, MIN_MOD, HR_MOD);
    localparam logic [W:0]  FMOD_VAL = (W+1)'(FMOD);

    assign ld_bad[gi] = ({1'b0, ld_vec[gi]} >= FMOD_VAL);

    mod_counter #(
      .MOD (FMOD),
      .W   (W)
    ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (carry[gi]),
      .down   (down),
      .load   (load),
      .ld_val (ld_vec[gi]),
      .cnt    (field_cnt[gi]),
      .wrap   (carry[gi+1])
    );
  end

  // Prescaler next value: cleared by load, frozen while paused, wraps on tick.
  always_comb begin
    pre_next = pre_reg;
    if (load) begin
      pre_next = '0;
    end else if (run) begin
      pre_next = tick ? '0 : (pre_reg + PW'(1));
    end
  end

  // Prescaler register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pre_reg <= '0;
    end else begin
      pre_reg <= pre_next;
    end
  end

  // Registered single-cycle event pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      sec_pulse_reg <= 1'b0;
      day_wrap_reg  <= 1'b0;
      load_err_reg  <= 1'b0;
    end else begin
      sec_pulse_reg <= tick;
      day_wrap_reg  <= carry[NUM_FIELDS];
      load_err_reg  <= load & (|ld_bad);
    end
  end

  assign sec_pulse = sec_pulse_reg;
  assign day_wrap  = day_wrap_reg;
  assign load_err  = load_err_reg;

endmodule

// File: tb/tb_hms_time_counter.sv
// Self-checking bench: directed scenarios then randomized traffic, compared
// every cycle against a seconds-of-day reference model.
module tb_hms_time_counter;

  localparam int TDIV = 4;
  localparam int DAY  = 24 * 60 * 60;

  logic       clk;
  logic       rst;
  logic       run;
  logic       down;
  logic       load;
  logic [7:0] ld_sec;
  logic [7:0] ld_min;
  logic [7:0] ld_hr;
  logic [7:0] sec;
  logic [7:0] min;
  logic [7:0] hr;
  logic       sec_pulse;
  logic       day_wrap;
  logic       load_err;

  int n_checks = 0;
  int n_fail   = 0;
  bit verbose  = 1'b1;

  // Reference model: time of day as a single count of seconds.
  int m_t   = 0;
  int m_pre = 0;
  int m_sp  = 0;
  int m_dw  = 0;
  int m_le  = 0;

  hms_time_counter #(
    .TICK_DIV (TDIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .down      (down),
    .load      (load),
    .ld_sec    (ld_sec),
    .ld_min    (ld_min),
    .ld_hr     (ld_hr),
    .sec       (sec),
    .min       (min),
    .hr        (hr),
    .sec_pulse (sec_pulse),
    .day_wrap  (day_wrap),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic cyc(input bit r, input bit ru, input bit dn, input bit ld,
                     input int ls, input int lm, input int lh);
    int s;
    int m;
    int h;
    rst    = r;
    run    = ru;
    down   = dn;
    load   = ld;
    ld_sec = 8'(ls);
    ld_min = 8'(lm);
    ld_hr  = 8'(lh);

    m_sp = 0;
    m_dw = 0;
    m_le = 0;
    if (r) begin
      m_t   = 0;
      m_pre = 0;
    end else if (ld) begin
      s     = (ls < 60) ? ls : 0;
      m     = (lm < 60) ? lm : 0;
      h     = (lh < 24) ? lh : 0;
      m_le  = ((ls >= 60) || (lm >= 60) || (lh >= 24)) ? 1 : 0;
      m_t   = h * 3600 + m * 60 + s;
      m_pre = 0;
    end else if (ru) begin
      if (m_pre == TDIV - 1) begin
        m_pre = 0;
        m_sp  = 1;
        if (dn) begin
          m_dw = (m_t == 0) ? 1 : 0;
          m_t  = (m_t + DAY - 1) % DAY;
        end else begin
          m_dw = (m_t == DAY - 1) ? 1 : 0;
          m_t  = (m_t + 1) % DAY;
        end
      end else begin
        m_pre++;
      end
    end

    @(posedge clk);
    #1;
    check("sec",       int'(sec),       m_t % 60);
    check("min",       int'(min),       (m_t / 60) % 60);
    check("hr",        int'(hr),        m_t / 3600);
    check("sec_pulse", int'(sec_pulse), m_sp);
    check("day_wrap",  int'(day_wrap),  m_dw);
    check("load_err",  int'(load_err),  m_le);
    if (verbose) begin
      $display("cyc rst=%0d run=%0d down=%0d load=%0d -> %02d:%02d:%02d sp=%0d dw=%0d le=%0d",
               r, ru, dn, ld, hr, min, sec, sec_pulse, day_wrap, load_err);
    end
  endtask

  task automatic idle(input int n, input bit ru, input bit dn);
    for (int i = 0; i < n; i++) cyc(1'b0, ru, dn, 1'b0, 0, 0, 0);
  endtask

  int  ls;
  int  lm;
  int  lh;
  bit  rnd_down;

  initial begin
    rst = 1'b1; run = 1'b0; down = 1'b0; load = 1'b0;
    ld_sec = '0; ld_min = '0; ld_hr = '0;

    // Reset, then free-run up from zero.
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 0, 0, 0);
    idle(9, 1'b1, 1'b0);

    // Minute-to-hour carry.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 59, 59, 0);
    idle(5, 1'b1, 1'b0);

    // Day overflow.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 59, 59, 23);
    idle(5, 1'b1, 1'b0);

    // Day underflow.
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 0, 0, 0);
    idle(5, 1'b1, 1'b1);

    // Out-of-range load.
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 75, 10, 30);
    idle(2, 1'b0, 1'b0);

    // Pause mid-second then resume.
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 0, 0, 0);
    idle(2, 1'b1, 1'b0);
    idle(10, 1'b0, 1'b0);
    idle(4, 1'b1, 1'b0);

    // Direction change mid-second, then reset colliding with a bad load.
    idle(2, 1'b1, 1'b0);
    idle(3, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b0, 1'b1, 75, 10, 30);
    idle(2, 1'b1, 1'b0);

    // Randomized traffic, loads biased toward field boundaries.
    verbose  = 1'b0;
    rnd_down = 1'b0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 39) == 0) rnd_down = ~rnd_down;
      if ($urandom_range(0, 1) == 0) begin
        ls = 58 + int'($urandom_range(0, 1));
        lm = 59;
        lh = ($urandom_range(0, 1) == 0) ? 23 : 0;
        if ($urandom_range(0, 1) == 0) begin
          ls = 0; lm = 0;
        end
      end else begin
        ls = int'($urandom_range(0, 255));
        lm = int'($urandom_range(0, 70));
        lh = int'($urandom_range(0, 30));
      end
      cyc(($urandom_range(0, 299) == 0), ($urandom_range(0, 9) != 0), rnd_down,
          ($urandom_range(0, 29) == 0), ls, lm, lh);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
